// File: rtl/bft_pkg.sv
// Shared constants and types for the BFT leaf stream blocks.
package bft_pkg;
    localparam int PACKET_BITS       = 97;
    localparam int MAX_NUM_OUT_PORTS = 7;
    localparam int PKT_VALID_BIT     = PACKET_BITS - 1;

    typedef logic [PACKET_BITS-1:0] packet_t;

    // Source that was granted in the previous cycle, i.e. whose dout is arriving now.
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_UPD  = 2'd1,
        SRC_DATA = 2'd2
    } src_e;
endpackage

// File: rtl/converge_arbiter_if.sv
// Queue-side and stream-side signals of the converged leaf arbiter.
interface converge_arbiter_if;
    import bft_pkg::*;

    logic [MAX_NUM_OUT_PORTS-1:0]  empty;
    packet_t [MAX_NUM_OUT_PORTS-1:0] packet_from_output_ports;
    logic                          upd_empty;
    packet_t                       upd_dout;
    logic                          resend;
    logic [MAX_NUM_OUT_PORTS-1:0]  outport_sel;
    logic                          upd_rd_en;
    packet_t                       stream_out;
    logic                          skid_full;

    modport master (
        input  empty, packet_from_output_ports, upd_empty, upd_dout, resend,
        output outport_sel, upd_rd_en, stream_out, skid_full
    );

    modport slave (
        output empty, packet_from_output_ports, upd_empty, upd_dout, resend,
        input  outport_sel, upd_rd_en, stream_out, skid_full
    );
endinterface

// File: rtl/converge_arbiter_rr_pick.sv
// Round-robin first-one finder: first set request at or above ptr, wrapping at N-1.
module rr_pick #(
    parameter int N = 7,
    parameter int W = 4
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx,
    output logic         any
);
    logic [W:0] cand;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int k = 0; k < N; k++) begin
            cand = {1'b0, ptr} + (W+1)'(k);
            if (cand >= (W+1)'(N))
                cand = cand - (W+1)'(N);
            for (int j = 0; j < N; j++) begin
                if (!any && cand == (W+1)'(j) && req[j]) begin
                    any = 1'b1;
                    idx = W'(j);
                end
            end
        end
        for (int j = 0; j < N; j++)
            gnt[j] = any && (idx == W'(j));
    end
endmodule

// File: rtl/converge_arbiter.sv
// Shares one output packet slot among the data queues and the update queue,
// with update priority under a burst cap and a one-entry skid for resend.
module converge_arbiter
    import bft_pkg::*;
#(
    parameter int NUM_OUT_PORTS = 7,
    parameter int NUM_PORT_BITS = 4,
    parameter int UPD_BURST     = 4
) (
    input  logic               clk_bft,
    input  logic               reset_bft_n,
    converge_arbiter_if.master bus
);
    localparam int BW = $clog2(UPD_BURST + 1);

    logic                     rst_rel;
    logic [NUM_PORT_BITS-1:0] rr_ptr;
    logic [NUM_PORT_BITS-1:0] pick_idx;
    logic [NUM_PORT_BITS-1:0] sel_port;
    logic [BW-1:0]            burst_cnt;
    src_e                     sel_src;
    packet_t                  skid;
    packet_t                  arriving;
    logic [NUM_OUT_PORTS-1:0] req;
    logic [NUM_OUT_PORTS-1:0] pick_gnt;
    logic                     pick_any;
    logic                     blocked;
    logic                     upd_gnt;
    logic                     data_gnt;

    assign req = ~bus.empty[NUM_OUT_PORTS-1:0];

    rr_pick #(.N(NUM_OUT_PORTS), .W(NUM_PORT_BITS)) u_pick (
        .req (req),
        .ptr (rr_ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    // rst_rel keeps read enables low for the first cycle after reset release.
    assign blocked  = bus.resend | bus.skid_full | ~rst_rel;
    assign upd_gnt  = ~blocked & ~bus.upd_empty &
                      ((burst_cnt < BW'(UPD_BURST)) | ~pick_any);
    assign data_gnt = ~blocked & ~upd_gnt & pick_any;

    assign bus.upd_rd_en = upd_gnt;

    always_comb begin
        bus.outport_sel = '0;
        for (int j = 0; j < NUM_OUT_PORTS; j++)
            bus.outport_sel[j] = data_gnt & pick_gnt[j];
    end

    always_comb begin
        arriving = '0;
        if (sel_src == SRC_UPD) begin
            arriving = bus.upd_dout;
        end else if (sel_src == SRC_DATA) begin
            for (int j = 0; j < NUM_OUT_PORTS; j++)
                if (sel_port == NUM_PORT_BITS'(j))
                    arriving = bus.packet_from_output_ports[j];
        end
    end

    always_ff @(posedge clk_bft or negedge reset_bft_n) begin
        if (!reset_bft_n) begin
            rst_rel   <= 1'b0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
            sel_src   <= SRC_NONE;
            sel_port  <= '0;
        end else begin
            rst_rel <= 1'b1;
            if (data_gnt)
                rr_ptr <= (pick_idx == NUM_PORT_BITS'(NUM_OUT_PORTS - 1)) ?
                          '0 : pick_idx + NUM_PORT_BITS'(1);
            if (data_gnt || bus.upd_empty)
                burst_cnt <= '0;
            else if (upd_gnt && burst_cnt < BW'(UPD_BURST))
                burst_cnt <= burst_cnt + BW'(1);
            sel_src  <= upd_gnt ? SRC_UPD : (data_gnt ? SRC_DATA : SRC_NONE);
            sel_port <= pick_idx;
        end
    end

    // An arrival never coincides with a full skid: grants stop while it is full.
    always_ff @(posedge clk_bft or negedge reset_bft_n) begin
        if (!reset_bft_n) begin
            bus.stream_out <= '0;
            bus.skid_full  <= 1'b0;
            skid           <= '0;
        end else if (bus.skid_full && !bus.resend) begin
            bus.stream_out <= skid;
            bus.skid_full  <= 1'b0;
        end else if (sel_src != SRC_NONE) begin
            if (bus.resend) begin
                skid          <= arriving;
                bus.skid_full <= 1'b1;
            end else begin
                bus.stream_out <= arriving;
            end
        end else if (!bus.resend) begin
            bus.stream_out <= '0;
        end
    end
endmodule

// File: tb/tb_converge_arbiter.sv
// Randomized scoreboard bench for converge_arbiter: a grant-policy model plus a
// packet-order scoreboard, and a 3-port instance checking pointer wrap.
module tb_converge_arbiter;
    import bft_pkg::*;

    localparam int NP = 7;
    localparam int UB = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    converge_arbiter_if ifc ();
    converge_arbiter_if ifc3 ();

    converge_arbiter #(.NUM_OUT_PORTS(NP), .NUM_PORT_BITS(4), .UPD_BURST(UB)) dut (
        .clk_bft     (clk),
        .reset_bft_n (rst_n),
        .bus         (ifc.master)
    );

    converge_arbiter #(.NUM_OUT_PORTS(3), .NUM_PORT_BITS(4), .UPD_BURST(UB)) dut3 (
        .clk_bft     (clk),
        .reset_bft_n (rst_n),
        .bus         (ifc3.master)
    );

    int checks = 0;
    int errors = 0;

    packet_t     dq[NP][$];
    packet_t     uq[$];
    packet_t     exp_q[$];
    int unsigned pkt_id = 0;
    logic [NP-1:0] g_sel = '0;
    logic          g_upd = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic mk_pkt(input int src, output packet_t p);
        p = '0;
        p[PKT_VALID_BIT] = 1'b1;
        p[95:88] = 8'(src);
        p[87:56] = pkt_id;
        p[31:0]  = $urandom;
        pkt_id++;
    endtask

    task automatic push_data(input int port);
        packet_t p;
        mk_pkt(port, p);
        dq[port].push_back(p);
        ifc.empty[port] = 1'b0;
    endtask

    task automatic push_upd();
        packet_t p;
        mk_pkt(8'hAA, p);
        uq.push_back(p);
        ifc.upd_empty = 1'b0;
    endtask

    function automatic int pending_total();
        int s;
        s = exp_q.size() + uq.size();
        for (int i = 0; i < NP; i++) s += dq[i].size();
        return s;
    endfunction

    // Queue model with read latency 1: the grant seen before the edge is popped after it.
    task automatic step();
        packet_t p;
        @(posedge clk);
        #1;
        for (int i = 0; i < NP; i++) begin
            if (g_sel[i] && dq[i].size() > 0) begin
                p = dq[i].pop_front();
                ifc.packet_from_output_ports[i] = p;
                exp_q.push_back(p);
            end
        end
        if (g_upd && uq.size() > 0) begin
            p = uq.pop_front();
            ifc.upd_dout = p;
            exp_q.push_back(p);
        end
        for (int i = 0; i < NP; i++) ifc.empty[i] = (dq[i].size() == 0);
        ifc.upd_empty = (uq.size() == 0);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (n < 400 && pending_total() > 0) begin
            step();
            n++;
        end
        check(name, pending_total(), 0);
    endtask

    // Grant-policy reference model, evaluated mid-cycle on the settled inputs.
    int m_rr, m_burst, m_prev, m_eg;
    bit m_skid, m_first, m_any, m_found;
    logic [NP-1:0] m_esel;
    always @(negedge clk) begin
        if (!rst_n) begin
            m_rr = 0; m_burst = 0; m_prev = -1; m_skid = 0; m_first = 1;
            check("rst_sel", ifc.outport_sel, 0);
            check("rst_upd", ifc.upd_rd_en, 0);
            check("rst_stream", ifc.stream_out, 0);
            check("rst_skid", ifc.skid_full, 0);
            g_sel = '0;
            g_upd = 1'b0;
        end else begin
            m_any = 0;
            for (int i = 0; i < NP; i++) if (!ifc.empty[i]) m_any = 1;
            m_eg = -1;
            if (!(ifc.resend || m_skid || m_first)) begin
                if (!ifc.upd_empty && (m_burst < UB || !m_any)) begin
                    m_eg = NP;
                end else begin
                    m_found = 0;
                    for (int k = 0; k < NP; k++) begin
                        if (!m_found && !ifc.empty[(m_rr + k) % NP]) begin
                            m_found = 1;
                            m_eg = (m_rr + k) % NP;
                        end
                    end
                end
            end
            m_esel = '0;
            if (m_eg >= 0 && m_eg < NP) m_esel[m_eg] = 1'b1;
            check("grant_sel", ifc.outport_sel, m_esel);
            check("grant_upd", ifc.upd_rd_en, m_eg == NP);
            check("skid_full", ifc.skid_full, m_skid);
            g_sel = ifc.outport_sel;
            g_upd = ifc.upd_rd_en;
            if (m_eg >= 0 && m_eg < NP) m_rr = (m_eg + 1) % NP;
            if ((m_eg >= 0 && m_eg < NP) || ifc.upd_empty) m_burst = 0;
            else if (m_eg == NP && m_burst < UB) m_burst++;
            if (m_skid && !ifc.resend) m_skid = 0;
            else if (m_prev >= 0 && ifc.resend) m_skid = 1;
            m_prev = m_eg;
            m_first = 0;
        end
    end

    // Output monitor: every read packet appears exactly once, in read order.
    packet_t mon_out, mon_prev, mon_exp;
    bit      mon_prev_res;
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_prev = '0;
            mon_prev_res = 0;
        end else begin
            mon_out = ifc.stream_out;
            if (mon_prev_res) begin
                check("hold", mon_out, mon_prev);
            end else if (mon_out[PKT_VALID_BIT]) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pkt", mon_out, 0);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("stream_data", mon_out, mon_exp);
                end
            end else begin
                check("idle_zero", mon_out, 0);
            end
            check("latency_pending", exp_q.size() <= 1, 1);
            mon_prev = mon_out;
            mon_prev_res = ifc.resend;
        end
    end

    // Three-port instance: always-requesting ports must be served 0,1,2,0,...
    int p3;
    bit f3;
    always @(negedge clk) begin
        if (!rst_n) begin
            p3 = 0;
            f3 = 1;
        end else begin
            check("p3_upper", ifc3.outport_sel[6:3], 0);
            if (f3) begin
                check("p3_first", ifc3.outport_sel, 0);
            end else begin
                check("p3_wrap", ifc3.outport_sel, 128'(1) << p3);
                p3 = (p3 + 1) % 3;
            end
            f3 = 0;
        end
    end

    initial begin
        ifc.empty = '1;
        ifc.upd_empty = 1'b1;
        ifc.resend = 1'b0;
        ifc.packet_from_output_ports = '0;
        ifc.upd_dout = '0;
        ifc3.empty = '0;
        ifc3.upd_empty = 1'b1;
        ifc3.resend = 1'b0;
        ifc3.packet_from_output_ports = '0;
        ifc3.upd_dout = '0;

        repeat (3) step();
        rst_n = 1'b1;

        // idle: nothing granted, stream stays zero
        repeat (6) step();

        // ports 0,3,5 round robin
        for (int r = 0; r < 4; r++) begin
            push_data(0); push_data(3); push_data(5);
        end
        repeat (16) step();

        // update burst cap against one data port
        repeat (10) push_upd();
        repeat (4) push_data(2);
        repeat (20) step();

        // resend right after a port-4 grant
        repeat (3) push_data(4);
        step();
        ifc.resend = 1'b1;
        repeat (3) step();
        ifc.resend = 1'b0;
        repeat (8) step();

        // random traffic with random resend
        for (int c = 0; c < 400; c++) begin
            step();
            if ($urandom_range(0, 3) == 0) push_data(int'($urandom_range(0, NP - 1)));
            if ($urandom_range(0, 4) == 0) push_upd();
            ifc.resend = ($urandom_range(0, 5) == 0);
        end
        ifc.resend = 1'b0;
        drain("drain_random");

        // asynchronous reset in the middle of an update burst
        repeat (12) push_upd();
        push_data(1);
        push_data(6);
        repeat (3) step();
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("async_rst_sel", ifc.outport_sel, 0);
        check("async_rst_upd", ifc.upd_rd_en, 0);
        check("async_rst_stream", ifc.stream_out, 0);
        check("async_rst_skid", ifc.skid_full, 0);
        repeat (2) step();
        rst_n = 1'b1;
        drain("drain_after_reset");
        repeat (4) step();
        check("final_pending", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/converge_arbiter.md
# converge_arbiter

Work-conserving scheduler for the converged BFT leaf stream. It shares one output packet slot among up to seven output-port queues and one freespace-update queue. Update packets have priority, limited by a burst cap. Data ports are served round-robin and empty ports are skipped, so no cycle is spent polling an idle port. Downstream resend is absorbed with a one-entry skid register, so no packet read from a queue is ever lost.

## Interface
- PACKET_BITS, 97, packet width; bit PACKET_BITS-1 is the packet-valid flag.
- NUM_OUT_PORTS, 7, number of data queues (1..7).
- NUM_PORT_BITS, 4, width of the round-robin pointer.
- UPD_BURST, 4, maximum consecutive update grants while any data queue is non-empty (≥1).

Ports:
- clk_bft  in  1  single clock.
- reset_bft_n  in  1  asynchronous, active-low reset.
- empty  in  NUM_OUT_PORTS  per-data-queue empty flag.
- packet_from_output_ports  in  PACKET_BITS*7  data queue outputs, port i at slice i; read latency 1.
- upd_empty  in  1  update queue empty.
- upd_dout  in  PACKET_BITS  update queue output; read latency 1.
- resend  in  1  downstream stall: hold stream_out.
- outport_sel  out  7  one-hot read enable to the data queues; bits ≥ NUM_OUT_PORTS are always 0.
- upd_rd_en  out  1  read enable to the update queue.
- stream_out  out  PACKET_BITS  converged packet (registered).
- skid_full  out  1  skid register occupied (status).

## Operation
- Grant stage (combinational from registered state and live inputs):
  - No grant at all if resend=1 or skid_full=1.
  - Otherwise grant the update queue if upd_empty=0 and (burst_cnt < UPD_BURST or all data queues are empty).
  - Otherwise grant the first non-empty data port, searching upward from rr_ptr and wrapping at NUM_OUT_PORTS-1 → 0.
  - Grants are one-hot: at most one of outport_sel and upd_rd_en is high.
- Registered state:
  - rr_ptr: after a grant to port i, rr_ptr ← (i == NUM_OUT_PORTS-1) ? 0 : i+1. Unchanged when there is no data grant.
  - burst_cnt: increments on an update grant and saturates at UPD_BURST. Clears to 0 on any data grant, or when upd_empty=1.
  - sel_d: which source was granted last cycle (none / update / data port index).
  - skid, skid_full.
- Capture stage (cycle after a grant):
  - The granted source's dout is "arriving".
  - If resend=0: stream_out ← arriving packet.
  - If resend=1: skid ← arriving packet, skid_full ← 1, stream_out is held.
  - With no arrival and resend=0: stream_out ← 0 (idle packet, valid bit 0).
  - With no arrival and resend=1: stream_out is held.
- Drain:
  - When skid_full=1 and resend=0: stream_out ← skid, skid_full ← 0.
  - Grants are blocked in that cycle and resume the next cycle.
  - skid_full=1 with a simultaneous arrival cannot occur, because grants are blocked while skid_full=1 or resend=1.
- Controller states, implicit in (resend, skid_full):
  - RUN (0,0).
  - HOLD (resend=1). Enter from RUN or DRAIN on resend=1; stay while resend=1.
  - DRAIN (resend=0, skid_full=1): lasts exactly one cycle, then RUN.
  - HOLD → RUN directly if skid_full=0.
- Reset (async, mid-operation allowed) sets:
  - stream_out=0, skid=0, skid_full=0;
  - rr_ptr=0, burst_cnt=0, sel_d=none;
  - outport_sel=0, upd_rd_en=0, because they are gated by a registered reset-release flag for the first cycle after deassertion.

## Timing
- Grant at cycle t → stream_out valid at the t+1 clock edge (latency 1 from read enable).
- Throughput: one packet per cycle in RUN with no idle bubbles while any queue is non-empty.
- Resend rising in cycle t:
  - No grants from t onward.
  - A grant issued at t-1 lands in skid at edge t.
- Resend falling in cycle t:
  - If skid_full: skid is output at edge t+1 and grants resume at t+1.
  - Otherwise grants resume at t.
- Starvation bound: a non-empty data port is served within NUM_OUT_PORTS*(UPD_BURST+1) grant cycles.

## Structure
- Shared package `bft_pkg`: PACKET_BITS, MAX_NUM_OUT_PORTS=7, and the valid-bit index constant.
- One natural sub-module, `rr_pick`: a round-robin first-one finder (request vector + pointer → one-hot grant + index). It is reusable by the input-side update poller.
- Remaining logic (burst counter, skid register, capture mux) stays in the top module.

## Test plan
- Ports 0, 3, 5 non-empty with constant data, upd_empty=1 → outport_sel sequence 1, 8, 32, 1, …; stream_out follows one cycle later with no idle cycles.
- Update queue holds 10 packets, port 2 non-empty, UPD_BURST=4 → grant pattern U U U U P2 U U U U P2 U U.
- Grant to port 4 at t, resend=1 at t+1 for 3 cycles → skid_full=1 and stream_out held. After release: skid packet out next cycle, then grants resume; no packet is duplicated or dropped (scoreboard count check).
- All queues empty → stream_out=0 every cycle, outport_sel=0, upd_rd_en=0.
- reset_bft_n pulsed low mid-burst, asynchronous to the clock → all outputs 0 immediately; first grant after release goes to port 0 (or to the update queue if non-empty).
- NUM_OUT_PORTS=3, all non-empty → pointer wraps 0, 1, 2, 0; outport_sel[6:3] never set.
